seq_detect_ctrl: RTL and testbench

Sequencing controller for the serial sequence detectors (Mealy/Moore `flag`/`din` style). It accepts parallel words over a valid/ready handshake and serializes each word MSB-first onto the detector `din`. It can optionally clear the detector before each word, counts detector `flag` pulses inside a latency-aligned window, and returns a per-word detection count over a second valid/ready handshake. It sits between a word-oriented producer/consumer and one detector instance.

---
 rtl/seq_detect_ctrl_pkg.sv | 16 +
 rtl/sat_counter.sv | 27 ++
 rtl/seq_detect_ctrl.sv | 97 +++++++++
 tb/tb_seq_detect_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_ctrl_pkg.sv
// rtl/seq_detect_ctrl_pkg.sv - shared state encodings and defaults for the detector sequencing controller
package seq_detect_ctrl_pkg;

    // Binary, registered state encoding.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SHIFT  = 3'd2,
        S_DRAIN  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_CNT_W  = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear and enable
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   clr       : synchronous clear to 0 (wins over en)
//   en        : increment by one, holding at all-ones
//   count     : current value
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - serializes words onto a sequence detector and reports per-word flag counts
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   in_valid/in_data/clr_mode     : word input handshake (clr_mode sampled with the word)
//   in_ready                      : high only when idle
//   det_din, det_clr, det_flag    : serial interface to one detector instance
//   out_valid/out_count/out_ready : per-word detection count handshake
//   busy                          : high whenever not idle
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter int WORD_W   = DEF_WORD_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int FLAG_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic              clr_mode,
    output logic              in_ready,
    output logic              det_din,
    output logic              det_clr,
    input  logic              det_flag,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_count,
    input  logic              out_ready,
    output logic              busy
);

    localparam int BW = $clog2(WORD_W);
    localparam logic [BW-1:0] LAST_IDX = BW'(WORD_W - 1);

    state_t            state, state_nx;
    logic [WORD_W-1:0] shreg;
    logic [BW-1:0]     bitcnt;
    logic              accept;
    logic              win;

    assign accept = (state == S_IDLE) && in_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            shreg  <= '0;
            bitcnt <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                shreg  <= in_data;
                bitcnt <= LAST_IDX;
            end else if (state == S_SHIFT) begin
                shreg  <= {shreg[WORD_W-2:0], 1'b0};
                bitcnt <= bitcnt - BW'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (in_valid) state_nx = clr_mode ? S_CLEAR : S_SHIFT;
            S_CLEAR:  state_nx = S_SHIFT;
            S_SHIFT:  if (bitcnt == '0) state_nx = (FLAG_LAT == 1) ? S_DRAIN : S_REPORT;
            S_DRAIN:  state_nx = S_REPORT;
            S_REPORT: if (out_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // The counting window is WORD_W cycles long; with a one-cycle flag latency
    // it slides by one, skipping the first shifted bit and covering DRAIN.
    always_comb begin
        win = 1'b0;
        if (FLAG_LAT == 1) begin
            win = ((state == S_SHIFT) && (bitcnt != LAST_IDX)) || (state == S_DRAIN);
        end else begin
            win = (state == S_SHIFT);
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (win && det_flag),
        .count (out_count)
    );

    // Every output is a decode of registered state only.
    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_REPORT);
    assign det_clr   = (state == S_CLEAR);
    assign det_din   = (state == S_SHIFT) ? shreg[WORD_W-1] : 1'b0;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - directed self-checking bench for seq_detect_ctrl
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       clr_mode;
    logic       det_flag;
    logic       out_ready;

    logic       in_ready0, det_din0, det_clr0, out_valid0, busy0;
    logic [3:0] out_count0;
    logic       in_ready1, det_din1, det_clr1, out_valid1, busy1;
    logic [3:0] out_count1;
    logic       in_ready2, det_din2, det_clr2, out_valid2, busy2;
    logic [1:0] out_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.WORD_W(8), .CNT_W(4), .FLAG_LAT(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_mode(clr_mode),
        .in_ready(in_ready0), .det_din(det_din0), .det_clr(det_clr0), .det_flag(det_flag),
        .out_valid(out_valid0), .out_count(out_count0), .out_ready(out_ready), .busy(busy0)
    );

    seq_detect_ctrl #(.WORD_W(8), .CNT_W(4), .FLAG_LAT(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_mode(clr_mode),
        .in_ready(in_ready1), .det_din(det_din1), .det_clr(det_clr1), .det_flag(det_flag),
        .out_valid(out_valid1), .out_count(out_count1), .out_ready(out_ready), .busy(busy1)
    );

    seq_detect_ctrl #(.WORD_W(8), .CNT_W(2), .FLAG_LAT(0)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_mode(clr_mode),
        .in_ready(in_ready2), .det_din(det_din2), .det_clr(det_clr2), .det_flag(det_flag),
        .out_valid(out_valid2), .out_count(out_count2), .out_ready(out_ready), .busy(busy2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word; returns in cycle T+1 of the acceptance edge T.
    task automatic send(input logic [7:0] data, input logic cm);
        in_data  = data;
        clr_mode = cm;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        clr_mode = 1'b0;
    endtask

    // Wait until every instance reports, then release all of them to IDLE.
    task automatic finish_word;
        int n;
        n = 0;
        while (!(out_valid0 && out_valid1 && out_valid2) && n < 20) begin
            tick();
            n++;
        end
        chk("report_timeout", 32'(n < 20), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        clr_mode  = 1'b0;
        det_flag  = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst_in_ready",  32'(in_ready0),  32'd1);
        chk("rst_busy",      32'(busy0),      32'd0);
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_det_din",   32'(det_din0),   32'd0);
        chk("rst_det_clr",   32'(det_clr0),   32'd0);
        chk("rst_out_count", 32'(out_count0), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Reset in the middle of SHIFT
        send(8'hFF, 1'b0);
        det_flag = 1'b1;
        tick();
        tick();
        tick();
        chk("mid_det_din",   32'(det_din0),   32'd1);
        chk("mid_busy",      32'(busy0),      32'd1);
        chk("mid_count",     32'(out_count0), 32'd3);
        rst = 1'b0;
        #1;
        chk("arst_in_ready",  32'(in_ready0),  32'd1);
        chk("arst_busy",      32'(busy0),      32'd0);
        chk("arst_out_valid", 32'(out_valid0), 32'd0);
        chk("arst_det_din",   32'(det_din0),   32'd0);
        chk("arst_det_clr",   32'(det_clr0),   32'd0);
        chk("arst_out_count", 32'(out_count0), 32'd0);
        det_flag = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        w = 8'h3C;
        send(w, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("post_rst_din", 32'(det_din0), 32'(w[7-i]));
            tick();
        end
        chk("post_rst_out_valid", 32'(out_valid0), 32'd1);
        finish_word();

        // A5 with clear
        w = 8'hA5;
        send(w, 1'b1);
        chk("clr_det_clr",   32'(det_clr0),   32'd1);
        chk("clr_det_din",   32'(det_din0),   32'd0);
        chk("clr_out_valid", 32'(out_valid0), 32'd0);
        tick();
        chk("clr_det_clr_off", 32'(det_clr0), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("a5_din", 32'(det_din0), 32'(w[7-i]));
            chk("a5_out_valid_early", 32'(out_valid0), 32'd0);
            tick();
        end
        chk("a5_out_valid", 32'(out_valid0), 32'd1);
        chk("a5_count",     32'(out_count0), 32'd0);
        finish_word();

        // Window, flags at SHIFT cycles 1, 4, 8 and cycle 9
        send(8'h00, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            det_flag = (c == 1 || c == 4 || c == 8 || c == 9);
            if (c == 9) begin
                chk("win0_out_valid", 32'(out_valid0), 32'd1);
                chk("win0_count",     32'(out_count0), 32'd3);
                chk("win1_drain",     32'(out_valid1), 32'd0);
            end
            tick();
        end
        det_flag = 1'b0;
        chk("win0_count_hold",  32'(out_count0), 32'd3);
        chk("win1_out_valid",   32'(out_valid1), 32'd1);
        chk("win1_count",       32'(out_count1), 32'd3);
        chk("win2_count",       32'(out_count2), 32'd3);
        finish_word();

        // Latency 1: flags in first SHIFT cycle and DRAIN
        send(8'h00, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            det_flag = (c == 1 || c == 9);
            if (c == 9) chk("lat1_out_valid_early", 32'(out_valid1), 32'd0);
            tick();
        end
        det_flag = 1'b0;
        chk("lat1_out_valid", 32'(out_valid1), 32'd1);
        chk("lat1_count",     32'(out_count1), 32'd1);
        finish_word();

        // Saturation
        send(8'h00, 1'b0);
        det_flag = 1'b1;
        for (int c = 1; c <= 8; c++) tick();
        det_flag = 1'b0;
        chk("sat_count2", 32'(out_count2), 32'd3);
        chk("sat_count0", 32'(out_count0), 32'd8);
        finish_word();

        // Backpressure
        send(8'h00, 1'b0);
        for (int c = 1; c <= 9; c++) tick();
        chk("bp_out_valid_all", 32'(out_valid0 && out_valid1 && out_valid2), 32'd1);
        in_data  = 8'h81;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_out_valid", 32'(out_valid0), 32'd1);
            chk("bp_in_ready",  32'(in_ready0),  32'd0);
            chk("bp_count",     32'(out_count0), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_in_ready",  32'(in_ready0),  32'd1);
        chk("bp_idle_out_valid", 32'(out_valid0), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("bp_accept_busy",    32'(busy0),    32'd1);
        chk("bp_accept_din",     32'(det_din0), 32'd1);
        finish_word();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
